// File: rtl/buzzer_pkg.sv
// ----------------------------------------------------------------------------
// buzzer_pkg - shared types and defaults for the buzzer arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package buzzer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_GAP  = 2'd2
   } arb_state_e;

   localparam int DEFAULT_N_CH = 3;

   // Same board clock the melody blocks use; the gap is a fixed 20 us silence
   localparam int CLK_FREQ_HZ        = 50_000_000;
   localparam int GAP_TIME_US        = 20;
   localparam int DEFAULT_GAP_CYCLES = CLK_FREQ_HZ / 1_000_000 * GAP_TIME_US;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick - combinational round-robin first-set-bit search from a pointer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_pick #(
   parameter int N     = 3,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic             valid_o,
   output logic [IDX_W-1:0] idx_o
);

   localparam logic [IDX_W:0] N_W = (IDX_W+1)'(N);

   logic [N-1:0]     rot;
   logic [IDX_W-1:0] off;
   logic [IDX_W:0]   sum;

   always_comb begin
      // Rotate so bit 0 is the pointer position, then find the lowest set bit
      rot     = N'({req_i, req_i} >> ptr_i);
      valid_o = 1'b0;
      off     = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (rot[k]) begin
            valid_o = 1'b1;
            off     = IDX_W'(k);
         end
      end
      sum   = {1'b0, ptr_i} + {1'b0, off};
      idx_o = (sum >= N_W) ? IDX_W'(sum - N_W) : sum[IDX_W-1:0];
   end

endmodule

`default_nettype wire

// File: rtl/buzzer_arbiter.sv
// ----------------------------------------------------------------------------
// buzzer_arbiter - round-robin arbiter of N melody channels onto one buzzer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module buzzer_arbiter
   import buzzer_pkg::*;
#(
   parameter int N_CH       = DEFAULT_N_CH,
   parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES,
   parameter int IDX_W      = $clog2(N_CH)
) (
   input  logic             clock_in,
   input  logic             reset_n,
   input  logic [N_CH-1:0]  req,
   input  logic [N_CH-1:0]  done,
   input  logic [N_CH-1:0]  buzzer_ch,
   input  logic             mute,
   output logic [N_CH-1:0]  grant,
   output logic             busy,
   output logic [IDX_W-1:0] active_idx,
   output logic             buzzer_para_placa
);

   localparam int             CNT_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int             GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
   localparam logic [IDX_W:0] N_W      = (IDX_W+1)'(N_CH);

   arb_state_e       state_q, state_d;
   logic [N_CH-1:0]  grant_q, grant_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] rr_q, rr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             buz_q, buz_d;

   logic             pick_valid;
   logic [IDX_W-1:0] pick_idx;
   logic [IDX_W:0]   pick_next;

   rr_pick #(
      .N     (N_CH),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .req_i   (req),
      .ptr_i   (rr_q),
      .valid_o (pick_valid),
      .idx_o   (pick_idx)
   );

   assign pick_next = {1'b0, pick_idx} + {{IDX_W{1'b0}}, 1'b1};

   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         idx_q   <= '0;
         rr_q    <= '0;
         cnt_q   <= '0;
         buz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         idx_q   <= idx_d;
         rr_q    <= rr_d;
         cnt_q   <= cnt_d;
         buz_q   <= buz_d;
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      idx_d   = idx_q;
      rr_d    = rr_q;
      cnt_d   = cnt_q;
      buz_d   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               state_d = ST_PLAY;
               grant_d = N_CH'(1) << pick_idx;
               idx_d   = pick_idx;
               rr_d    = (pick_next >= N_W) ? '0 : pick_next[IDX_W-1:0];
            end
         end
         ST_PLAY: begin
            // Only the granted channel can end the song; others keep waiting
            if (done[idx_q] || !req[idx_q]) begin
               grant_d = '0;
               cnt_d   = CNT_W'(GAP_LAST);
               state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
            end else begin
               buz_d = buzzer_ch[idx_q] & ~mute;
            end
         end
         ST_GAP: begin
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
      endcase
   end

   assign grant             = grant_q;
   assign busy              = (state_q != ST_IDLE);
   assign active_idx        = idx_q;
   assign buzzer_para_placa = buz_q;

endmodule

`default_nettype wire

// File: doc/buzzer_arbiter.md
Name: buzzer_arbiter

Overview:
Parametrised successor to the three-input buzzer OR-combiner. It arbitrates N_CH melody generators that request the single board buzzer. It grants exactly one channel at a time using round-robin fairness, and inserts a programmable silence gap between songs. It forwards only the granted channel's tone, registered and maskable by mute. It sits between the per-song melody blocks and the board buzzer pin.

Parameters:
N_CH, 3, number of melody channels (2..8)
GAP_CYCLES, 1000, clock cycles of forced silence after a song ends (0 allowed)
IDX_W, $clog2(N_CH), width of channel index (derived, not overridden)

Ports:
clock_in  in  1  system clock
reset_n  in  1  asynchronous active-low reset
req  in  N_CH  per-channel play request, level, held for the whole song
done  in  N_CH  per-channel single-cycle end-of-song pulse
buzzer_ch  in  N_CH  per-channel tone square wave
mute  in  1  forces buzzer output low; arbitration continues
grant  out  N_CH  one-hot grant, registered
busy  out  1  high in PLAY or GAP
active_idx  out  IDX_W  index of granted channel, valid while grant != 0
buzzer_para_placa  out  1  registered tone to the board buzzer

Behaviour:
- All inputs are synchronous to clock_in. The clock is named clock_in. Reset is asynchronous and active-low (reset_n).
- Reset values: state=IDLE, grant=0, busy=0, active_idx=0, buzzer_para_placa=0, rr_ptr=0, gap counter=0.
- FSM states: IDLE, PLAY, GAP.
- IDLE:
  - If req != 0, choose the first set bit scanning upward from rr_ptr, wrapping mod N_CH.
  - Register grant=onehot(i) and active_idx=i; go to PLAY; set rr_ptr=(i+1) mod N_CH.
  - If req == 0, stay in IDLE with the output low.
- PLAY:
  - buzzer_para_placa <= buzzer_ch[active_idx] & ~mute, giving 1-cycle latency from buzzer_ch.
  - Exit when done[active_idx]=1 or req[active_idx]=0.
  - On exit: grant<=0, output<=0, counter<=GAP_CYCLES-1, go to GAP. If GAP_CYCLES=0, go straight to IDLE.
  - done/req of non-granted channels are ignored. Other requests wait and are never dropped.
- GAP:
  - Output 0, grant 0, busy 1.
  - Counter decrements each cycle; at 0 go to IDLE.
  - Arbitration happens on the IDLE cycle that follows, so a waiting request is granted GAP_CYCLES+1 cycles after the exit cycle.
- Simultaneous events:
  - done and req-drop in the same cycle count as one exit.
  - A new req arriving on the exit cycle is only seen in IDLE.
  - The granted channel re-raising req during GAP is treated as a fresh request, with rr priority after the other channels.
- Mute: purely masks the output, registered with the same 1-cycle latency. It does not affect the FSM, grant or busy.
- Reset mid-song: all outputs go to 0 immediately (asynchronous assertion). After deassertion the block is in IDLE with rr_ptr=0.
- Invariant: grant is zero or one-hot. buzzer_para_placa is 0 whenever grant=0.

Decomposition:
- Shared package buzzer_pkg: state enum (IDLE, PLAY, GAP), default N_CH, and the GAP_CYCLES default derived from the clock frequency constant used by the melody blocks.
- One natural sub-module, rr_pick: combinational round-robin first-set-bit search taking req and rr_ptr and returning valid and index. It is reusable elsewhere.

Test Plan:
All scenarios use N_CH=3, GAP_CYCLES=4.
1. Reset, then req=3'b000 for 20 cycles -> grant=0, busy=0, buzzer_para_placa=0 throughout.
2. req=3'b010, buzzer_ch[1] toggling -> grant=3'b010 one cycle later. Output equals buzzer_ch[1] delayed 1 cycle, with buzzer_ch[0]/[2] activity ignored. done[1] pulse -> grant=0 next cycle. busy stays high for 4 GAP cycles, then falls.
3. req=3'b111 continuous with each song ended by done after 10 cycles -> grant sequence 001, 010, 100, 001. Grants are separated by 4 silent cycles plus 1 IDLE cycle, and there is never a double grant.
4. mute=1 mid-PLAY for 6 cycles -> output 0 for exactly those cycles (shifted by 1). grant and busy are unchanged, and the song continues afterwards.
5. Granted channel drops req without done -> same GAP entry as done. done pulse on a non-granted channel -> no effect.
6. reset_n asserted low mid-PLAY while output=1 -> output, grant and busy go to 0 asynchronously. After release, req=3'b100 is granted from IDLE with rr_ptr=0.
